demuxn_reg: RTL and testbench

Registered 1-to-2^NB_SEL demultiplexer with valid/ready handshakes. It is the splitting counterpart of the n-select mux: one producer stream is routed to one of 2^NB_SEL consumer channels. The channel is chosen by a per-word selector. Each channel owns a single-entry output register, so consumers stall independently of one another. It sits between a shared bus source and per-unit sinks.

---
 rtl/demuxn_reg.sv | 70 +++++++
 tb/tb_demuxn_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demuxn_reg.sv
// demuxn_reg: registered 1-to-2^NB_SEL demultiplexer with valid/ready handshakes.
// One producer stream is steered by a per-word selector into one of several
// single-entry channel registers. Each channel drains independently and keeps
// a wrapping count of delivered words.
module demuxn_reg #(
  parameter int NB_SEL = 2,
  parameter int WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [NB_SEL-1:0]             in_sel,
  output logic [(2**NB_SEL)-1:0]        out_valid,
  input  logic [(2**NB_SEL)-1:0]        out_ready,
  output logic [(2**NB_SEL)*WIDTH-1:0]  out_data,
  output logic [(2**NB_SEL)*8-1:0]      count,
  output logic                          busy
);

  localparam int NCH = 2 ** NB_SEL;

  logic            w_sel_free;
  logic            w_accept;
  logic [NCH-1:0]  w_load;
  logic [NCH-1:0]  w_drain;

  // Only the addressed channel gates the input: it must be empty or draining
  // at this edge. Other channels never block, and never unblock, the stream.
  assign w_sel_free = !out_valid[in_sel] || out_ready[in_sel];
  assign in_ready   = !reset && w_sel_free;
  assign w_accept   = in_valid && in_ready;
  assign busy       = |out_valid;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [7:0]       r_count;

    assign w_load[gi]  = w_accept && (in_sel == NB_SEL'(gi));
    assign w_drain[gi] = r_valid && out_ready[gi];

    // Channel register: a load wins over a drain so a simultaneous drain and
    // reload keeps the channel full with the new word (1 word/cycle/channel).
    // The delivered-word counter steps on every drain and wraps naturally.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_count <= 8'd0;
      end else begin
        if (w_load[gi]) begin
          r_valid <= 1'b1;
          r_data  <= in_data;
        end else if (w_drain[gi]) begin
          r_valid <= 1'b0;
        end
        if (w_drain[gi]) begin
          r_count <= r_count + 8'd1;
        end
      end
    end

    assign out_valid[gi]                 = r_valid;
    assign out_data[gi*WIDTH +: WIDTH]   = r_data;
    assign count[gi*8 +: 8]              = r_count;
  end

endmodule

// File: tb/tb_demuxn_reg.sv
// tb_demuxn_reg: directed scenarios with literal expectations, followed by a
// randomized stream, all watched cycle-by-cycle by a behavioural channel model.
module tb_demuxn_reg;

  localparam int NB  = 2;
  localparam int W   = 8;
  localparam int NCH = 1 << NB;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic [NB-1:0]     in_sel;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [NCH*W-1:0]  out_data;
  logic [NCH*8-1:0]  count;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: what each channel holds and how many words it delivered.
  bit          m_valid [NCH];
  logic [W-1:0] m_data [NCH];
  int          m_cnt   [NCH];

  demuxn_reg #(.NB_SEL(NB), .WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: at each falling edge the DUT outputs must match the model,
  // then the model predicts the effect of the coming rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit          exp_ready;
      logic [NCH-1:0] exp_valid;
      exp_ready = !reset && (!m_valid[in_sel] || out_ready[in_sel]);
      check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
      for (int k = 0; k < NCH; k++) exp_valid[k] = m_valid[k];
      check("out_valid", {60'd0, out_valid}, {60'd0, exp_valid});
      check("busy", {63'd0, busy}, {63'd0, (exp_valid != 0)});
      for (int k = 0; k < NCH; k++) begin
        check($sformatf("count[%0d]", k), {56'd0, count[k*8 +: 8]}, 64'(m_cnt[k] % 256));
        if (m_valid[k])
          check($sformatf("out_data[%0d]", k), {56'd0, out_data[k*W +: W]}, {56'd0, m_data[k]});
      end
      if (reset) begin
        for (int k = 0; k < NCH; k++) begin
          m_valid[k] = 1'b0;
          m_data[k]  = '0;
          m_cnt[k]   = 0;
        end
      end else begin
        for (int k = 0; k < NCH; k++) begin
          if (m_valid[k] && out_ready[k]) begin
            m_cnt[k]   = m_cnt[k] + 1;
            m_valid[k] = 1'b0;
          end
        end
        if (in_valid && exp_ready) begin
          m_valid[in_sel] = 1'b1;
          m_data[in_sel]  = in_data;
        end
      end
    end
  end

  // Inputs change just after the rising edge, so they are stable at the
  // falling-edge compare and at the next rising edge.
  task automatic drive(input logic rst, input logic v, input logic [NB-1:0] s,
                       input logic [W-1:0] d, input logic [NCH-1:0] rdy);
    @(posedge clk);
    #1;
    reset     = rst;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = rdy;
    #1;
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
      m_cnt[k]   = 0;
    end
    reset = 1'b1; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hAA; out_ready = '0;

    // Reset held two cycles with a word offered.
    drive(1'b1, 1'b1, 2'd1, 8'hAA, 4'b0000);
    chk_en = 1'b1;
    check("rst in_ready", {63'd0, in_ready}, 64'd0);
    check("rst out_valid", {60'd0, out_valid}, 64'd0);
    check("rst count", {32'd0, count}, 64'd0);
    check("rst out_data", {32'd0, out_data}, 64'd0);
    drive(1'b1, 1'b1, 2'd1, 8'hAA, 4'b0000);
    check("rst2 in_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b0, 1'b0, 2'd1, 8'hAA, 4'b0000);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    check("post-rst no load", {60'd0, out_valid}, 64'd0);

    // Routing to each channel with all consumers ready.
    drive(1'b0, 1'b1, 2'd0, 8'h11, 4'b1111);
    drive(1'b0, 1'b1, 2'd1, 8'h22, 4'b1111);
    check("route ch0 valid", {60'd0, out_valid}, 64'h1);
    check("route ch0 data", {56'd0, out_data[7:0]}, 64'h11);
    drive(1'b0, 1'b1, 2'd2, 8'h33, 4'b1111);
    check("route ch1 valid", {60'd0, out_valid}, 64'h2);
    drive(1'b0, 1'b1, 2'd3, 8'h44, 4'b1111);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    check("route ch3 data", {56'd0, out_data[31:24]}, 64'h44);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    check("route counts", {32'd0, count}, 64'h01010101);

    // Backpressure isolation on channel 2.
    drive(1'b0, 1'b1, 2'd2, 8'h55, 4'b1011);
    drive(1'b0, 1'b1, 2'd2, 8'h66, 4'b1011);
    check("bp blocked", {63'd0, in_ready}, 64'd0);
    drive(1'b0, 1'b1, 2'd0, 8'h77, 4'b1011);
    check("bp other ch ready", {63'd0, in_ready}, 64'd1);
    drive(1'b0, 1'b1, 2'd2, 8'h66, 4'b0010);
    check("bp held valid", {60'd0, out_valid}, 64'h5);
    check("bp ch2 held", {56'd0, out_data[23:16]}, 64'h55);
    drive(1'b0, 1'b1, 2'd2, 8'h66, 4'b1111);
    check("bp released", {63'd0, in_ready}, 64'd1);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    check("bp ch2 data", {56'd0, out_data[23:16]}, 64'h66);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);

    // Simultaneous drain and load on channel 1.
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
    drive(1'b0, 1'b1, 2'd1, 8'hA0, 4'b0000);
    drive(1'b0, 1'b1, 2'd1, 8'hA1, 4'b0010);
    check("dl in_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    check("dl data", {56'd0, out_data[15:8]}, 64'hA1);
    check("dl valid", {63'd0, out_valid[1]}, 64'd1);
    check("dl count", {56'd0, count[15:8]}, 64'd1);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);

    // Counter wrap: 257 words to channel 3.
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111);
    for (int i = 0; i < 257; i++) drive(1'b0, 1'b1, 2'd3, 8'(i), 4'b1111);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    check("wrap counts", {32'd0, count}, 64'h01000000);

    // Reset mid-operation with channels 0 and 3 full and stalled.
    drive(1'b0, 1'b1, 2'd0, 8'hC0, 4'b0000);
    drive(1'b0, 1'b1, 2'd3, 8'hC3, 4'b0000);
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
    check("mid full before rst", {60'd0, out_valid}, 64'h9);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    check("mid out_valid", {60'd0, out_valid}, 64'd0);
    check("mid busy", {63'd0, busy}, 64'd0);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    check("mid no delivery", {32'd0, count}, 64'd0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            NB'($urandom_range(0, NCH - 1)), W'($urandom),
            NCH'($urandom));
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    @(negedge clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
